// File: rtl/trolley_billing.sv
// Shopping-trolley billing engine: programmable product table, scan add/remove
// with stock tracking, running bill, item count and a timed door-open pulse.
module trolley_billing #(
  parameter int N_PROD   = 5,
  parameter int BC_W     = 16,
  parameter int COST_W   = 10,
  parameter int QTY_W    = 10,
  parameter int CAP      = 8,
  parameter int DOOR_CYC = 4,
  parameter int TOT_W    = 14,
  localparam int IDX_W   = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [BC_W-1:0]   prog_barcode,
  input  logic [COST_W-1:0] prog_cost,
  input  logic [QTY_W-1:0]  prog_qty,
  input  logic              scan_valid,
  input  logic              scan_op,
  input  logic [BC_W-1:0]   barcode,
  input  logic              checkout,
  output logic              scan_ready,
  output logic              resp_valid,
  output logic [1:0]        resp_status,
  output logic [IDX_W-1:0]  resp_idx,
  output logic [TOT_W-1:0]  total_cost,
  output logic [7:0]        item_count,
  output logic              trolley_full,
  output logic              door_open
);

  localparam int DC_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_NOT_FOUND = 2'd1;
  localparam logic [1:0] ST_NO_ITEM   = 2'd2;
  localparam logic [1:0] ST_FULL      = 2'd3;

  if (TOT_W < COST_W + $clog2(CAP + 1)) begin : g_tot_chk
    $error("TOT_W too narrow for CAP items of COST_W cost");
  end
  if (CAP < 1 || CAP > 255) begin : g_cap_chk
    $error("CAP must be in 1..255");
  end
  if (DOOR_CYC < 1) begin : g_door_chk
    $error("DOOR_CYC must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_DOOR} state_t;

  state_t             state_q, state_d;
  logic [BC_W-1:0]    scan_bc_q, scan_bc_d;
  logic               scan_op_q, scan_op_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_status_q, resp_status_d;
  logic [IDX_W-1:0]   resp_idx_q, resp_idx_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [7:0]         count_q, count_d;
  logic               door_q, door_d;
  logic [DC_W-1:0]    door_cnt_q, door_cnt_d;

  logic               valid_q   [N_PROD];
  logic               valid_d   [N_PROD];
  logic [BC_W-1:0]    bc_mem_q  [N_PROD];
  logic [BC_W-1:0]    bc_mem_d  [N_PROD];
  logic [COST_W-1:0]  cost_q    [N_PROD];
  logic [COST_W-1:0]  cost_d    [N_PROD];
  logic [QTY_W-1:0]   qty_q     [N_PROD];
  logic [QTY_W-1:0]   qty_d     [N_PROD];
  logic [7:0]         in_cart_q [N_PROD];
  logic [7:0]         in_cart_d [N_PROD];

  logic [N_PROD-1:0]  match_vec;
  logic               found;
  logic [IDX_W-1:0]   found_idx;
  logic [COST_W-1:0]  sel_cost;
  logic [QTY_W-1:0]   sel_qty;
  logic [7:0]         sel_cart;
  logic [TOT_W-1:0]   cost_ext;
  logic               do_checkout, do_prog, upd_ok;

  assign scan_ready  = (state_q == S_IDLE) && !prog_we && !checkout;
  assign do_checkout = (state_q == S_IDLE) && checkout;
  assign do_prog     = (state_q == S_IDLE) && !checkout && prog_we;

  for (genvar gi = 0; gi < N_PROD; gi++) begin : g_match
    assign match_vec[gi] = valid_q[gi] && (bc_mem_q[gi] == scan_bc_q);
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_cost = '0;
    sel_qty  = '0;
    sel_cart = '0;
    for (int i = 0; i < N_PROD; i++) begin
      if (hit_idx_q == IDX_W'(i)) begin
        sel_cost = cost_q[i];
        sel_qty  = qty_q[i];
        sel_cart = in_cart_q[i];
      end
    end
  end

  assign cost_ext = {{(TOT_W - COST_W){1'b0}}, sel_cost};

  always_comb begin
    state_d       = state_q;
    scan_bc_d     = scan_bc_q;
    scan_op_d     = scan_op_q;
    hit_d         = hit_q;
    hit_idx_d     = hit_idx_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    resp_idx_d    = resp_idx_q;
    total_d       = total_q;
    count_d       = count_q;
    door_d        = door_q;
    door_cnt_d    = door_cnt_q;
    upd_ok        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (do_checkout) begin
          total_d = '0;
          count_d = '0;
        end else if (!prog_we && scan_valid) begin
          scan_bc_d = barcode;
          scan_op_d = scan_op;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        hit_d     = found;
        hit_idx_d = found_idx;
        state_d   = S_UPDATE;
      end
      S_UPDATE: begin
        resp_valid_d = 1'b1;
        resp_idx_d   = hit_idx_q;
        if (!hit_q) begin
          resp_status_d = ST_NOT_FOUND;
        end else if (!scan_op_q) begin
          if (count_q == 8'(CAP))  resp_status_d = ST_FULL;
          else if (sel_qty == '0)  resp_status_d = ST_NO_ITEM;
          else                     resp_status_d = ST_OK;
        end else begin
          resp_status_d = (sel_cart == '0) ? ST_NO_ITEM : ST_OK;
        end
        if (resp_status_d == ST_OK) begin
          upd_ok     = 1'b1;
          total_d    = scan_op_q ? (total_q - cost_ext) : (total_q + cost_ext);
          count_d    = scan_op_q ? (count_q - 8'd1) : (count_q + 8'd1);
          door_d     = 1'b1;
          door_cnt_d = DC_W'(DOOR_CYC - 1);
          state_d    = S_DOOR;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_DOOR: begin
        if (door_cnt_q == '0) begin
          door_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          door_cnt_d = door_cnt_q - DC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stock saturates at all-ones on removal so an over-stocked entry never wraps to zero.
  always_comb begin
    for (int i = 0; i < N_PROD; i++) begin
      valid_d[i]   = valid_q[i];
      bc_mem_d[i]  = bc_mem_q[i];
      cost_d[i]    = cost_q[i];
      qty_d[i]     = qty_q[i];
      in_cart_d[i] = in_cart_q[i];
      if (do_prog && prog_idx == IDX_W'(i)) begin
        valid_d[i]  = 1'b1;
        bc_mem_d[i] = prog_barcode;
        cost_d[i]   = prog_cost;
        qty_d[i]    = prog_qty;
      end
      if (do_checkout) in_cart_d[i] = '0;
      if (upd_ok && hit_idx_q == IDX_W'(i)) begin
        if (!scan_op_q) begin
          qty_d[i]     = qty_q[i] - QTY_W'(1);
          in_cart_d[i] = in_cart_q[i] + 8'd1;
        end else begin
          if (qty_q[i] != '1) qty_d[i] = qty_q[i] + QTY_W'(1);
          in_cart_d[i] = in_cart_q[i] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      scan_bc_q     <= '0;
      scan_op_q     <= 1'b0;
      hit_q         <= 1'b0;
      hit_idx_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_idx_q    <= '0;
      total_q       <= '0;
      count_q       <= '0;
      door_q        <= 1'b0;
      door_cnt_q    <= '0;
      for (int i = 0; i < N_PROD; i++) begin
        valid_q[i]   <= 1'b0;
        bc_mem_q[i]  <= '0;
        cost_q[i]    <= '0;
        qty_q[i]     <= '0;
        in_cart_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      scan_bc_q     <= scan_bc_d;
      scan_op_q     <= scan_op_d;
      hit_q         <= hit_d;
      hit_idx_q     <= hit_idx_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_idx_q    <= resp_idx_d;
      total_q       <= total_d;
      count_q       <= count_d;
      door_q        <= door_d;
      door_cnt_q    <= door_cnt_d;
      for (int i = 0; i < N_PROD; i++) begin
        valid_q[i]   <= valid_d[i];
        bc_mem_q[i]  <= bc_mem_d[i];
        cost_q[i]    <= cost_d[i];
        qty_q[i]     <= qty_d[i];
        in_cart_q[i] <= in_cart_d[i];
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_status  = resp_status_q;
  assign resp_idx     = resp_idx_q;
  assign total_cost   = total_q;
  assign item_count   = count_q;
  assign trolley_full = (count_q == 8'(CAP));
  assign door_open    = door_q;

endmodule

// File: tb/tb_trolley_billing.sv
// Scoreboard bench for trolley_billing: a behavioural trolley model pushes the
// expected response per scan; each scenario pops and compares when the DUT answers.
module tb_trolley_billing;

  localparam int CAP      = 8;
  localparam int DOOR_CYC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [2:0]  prog_idx;
  logic [15:0] prog_barcode;
  logic [9:0]  prog_cost;
  logic [9:0]  prog_qty;
  logic        scan_valid;
  logic        scan_op;
  logic [15:0] barcode;
  logic        checkout;
  logic        scan_ready;
  logic        resp_valid;
  logic [1:0]  resp_status;
  logic [2:0]  resp_idx;
  logic [13:0] total_cost;
  logic [7:0]  item_count;
  logic        trolley_full;
  logic        door_open;

  always #5 clk = ~clk;

  trolley_billing #(
    .N_PROD(5), .BC_W(16), .COST_W(10), .QTY_W(10),
    .CAP(CAP), .DOOR_CYC(DOOR_CYC), .TOT_W(14)
  ) dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_barcode(prog_barcode),
    .prog_cost(prog_cost), .prog_qty(prog_qty),
    .scan_valid(scan_valid), .scan_op(scan_op), .barcode(barcode),
    .checkout(checkout), .scan_ready(scan_ready),
    .resp_valid(resp_valid), .resp_status(resp_status), .resp_idx(resp_idx),
    .total_cost(total_cost), .item_count(item_count),
    .trolley_full(trolley_full), .door_open(door_open)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [2:0]  idx;
    logic [13:0] tot;
    logic [7:0]  cnt;
  } resp_t;

  resp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        m_valid [5];
  logic [15:0] m_bc    [5];
  int          m_cost  [5];
  int          m_qty   [5];
  int          m_cart  [5];
  int          m_total;
  int          m_count;

  function automatic string fmt(resp_t r);
    return $sformatf("st=%0d idx=%0d tot=%0d cnt=%0d", r.st, r.idx, r.tot, r.cnt);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 5; i++) begin
      m_valid[i] = 1'b0; m_bc[i] = '0; m_cost[i] = 0; m_qty[i] = 0; m_cart[i] = 0;
    end
    m_total = 0;
    m_count = 0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !scan_ready; k++) @(negedge clk);
  endtask

  task automatic prog(input int idx, input logic [15:0] bc, input int cost, input int qty);
    wait_ready();
    prog_we = 1'b1; prog_idx = 3'(idx); prog_barcode = bc;
    prog_cost = 10'(cost); prog_qty = 10'(qty);
    @(posedge clk); @(negedge clk);
    prog_we = 1'b0;
    if (idx < 5) begin
      m_valid[idx] = 1'b1; m_bc[idx] = bc; m_cost[idx] = cost; m_qty[idx] = qty;
    end
  endtask

  task automatic do_checkout();
    wait_ready();
    checkout = 1'b1;
    @(posedge clk); @(negedge clk);
    checkout = 1'b0;
    for (int i = 0; i < 5; i++) m_cart[i] = 0;
    m_total = 0;
    m_count = 0;
  endtask

  // Drives one scan, pushes the model's expectation, returns what the DUT answered.
  task automatic issue_scan(input logic op, input logic [15:0] bc,
                            output resp_t obs, output int lat, output bit door_seen);
    resp_t e;
    bit    fnd;
    int    fi;
    logic [1:0] st;
    wait_ready();
    scan_valid = 1'b1; scan_op = op; barcode = bc;
    fnd = 1'b0; fi = 0;
    for (int i = 0; i < 5; i++)
      if (!fnd && m_valid[i] && m_bc[i] == bc) begin fnd = 1'b1; fi = i; end
    if (!fnd) st = 2'd1;
    else if (!op) st = (m_count == CAP) ? 2'd3 : (m_qty[fi] == 0) ? 2'd2 : 2'd0;
    else st = (m_cart[fi] == 0) ? 2'd2 : 2'd0;
    if (st == 2'd0) begin
      if (!op) begin
        m_qty[fi]--; m_cart[fi]++; m_count++; m_total += m_cost[fi];
      end else begin
        if (m_qty[fi] != 1023) m_qty[fi]++;
        m_cart[fi]--; m_count--; m_total -= m_cost[fi];
      end
    end
    e = {st, 3'(fi), 14'(m_total), 8'(m_count)};
    sb_q.push_back(e);
    @(posedge clk); @(negedge clk);
    scan_valid = 1'b0;
    obs = 'x; lat = -1; door_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (resp_valid) begin
        obs = {resp_status, resp_idx, total_cost, item_count};
        lat = c - 1;
        break;
      end
      if (door_open) door_seen = 1'b1;
      @(negedge clk);
    end
    $display("scan op=%0d bc=%h -> %s lat=%0d", op, bc, fmt(obs), lat);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({resp_valid, resp_status, resp_idx, total_cost, item_count, trolley_full, door_open} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rv=%b st=%0d idx=%0d tot=%0d cnt=%0d full=%b door=%b, want all 0",
               resp_valid, resp_status, resp_idx, total_cost, item_count, trolley_full, door_open);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (scan_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", scan_ready); end
  endtask

  task automatic test_add_ok();
    resp_t o, e; int lat; bit ds; int dc; bit rdy_bad;
    prog(0, 16'hF0F0, 10, 16);
    issue_scan(1'b0, 16'hF0F0, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL add_ok_resp: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (lat != 2) begin n_bad++; $display("FAIL add_ok_latency: got %0d want 2", lat); end
    dc = 0; rdy_bad = 1'b0;
    while (door_open === 1'b1 && dc < 20) begin
      dc++;
      if (scan_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (dc != DOOR_CYC) begin n_bad++; $display("FAIL door_cycles: got %0d want %0d", dc, DOOR_CYC); end
    n_cmp++;
    if (rdy_bad) begin n_bad++; $display("FAIL ready_during_door: got ready=1 want 0"); end
    n_cmp++;
    if (scan_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_door: got %b want 1", scan_ready); end
  endtask

  task automatic test_not_found();
    resp_t o, e; int lat; bit ds;
    issue_scan(1'b0, 16'hABCD, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL nf_resp: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (ds || door_open !== 1'b0) begin n_bad++; $display("FAIL nf_door: got seen=%b door=%b want 0", ds, door_open); end
    n_cmp++;
    if (scan_ready !== 1'b1) begin n_bad++; $display("FAIL nf_ready: got %b want 1", scan_ready); end
  endtask

  task automatic test_no_stock();
    resp_t o, e; int lat; bit ds;
    prog(1, 16'h1111, 7, 1);
    for (int k = 0; k < 2; k++) begin
      issue_scan(1'b0, 16'h1111, o, lat, ds);
      e = sb_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL nostock_resp%0d: got %s want %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_full();
    resp_t o, e; int lat; bit ds;
    do_checkout();
    prog(2, 16'h2222, 3, 20);
    for (int k = 0; k < CAP + 1; k++) begin
      issue_scan(1'b0, 16'h2222, o, lat, ds);
      e = sb_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL full_resp%0d: got %s want %s", k, fmt(o), fmt(e)); end
      if (k == CAP - 2) begin
        n_cmp++;
        if (trolley_full !== 1'b0) begin n_bad++; $display("FAIL not_full_below_cap: got %b want 0", trolley_full); end
      end
    end
    n_cmp++;
    if (trolley_full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b want 1", trolley_full); end
    issue_scan(1'b0, 16'h1111, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL full_over_nostock: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_remove();
    resp_t o, e; int lat; bit ds;
    logic        ops [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] bcs [8] = '{16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555};
    do_checkout();
    prog(3, 16'h5555, 55, 4);
    for (int k = 0; k < 8; k++) begin
      issue_scan(ops[k], bcs[k], o, lat, ds);
      e = sb_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL remove_resp%0d: got %s want %s", k, fmt(o), fmt(e)); end
    end
    issue_scan(1'b1, 16'h9999, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL remove_unknown: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_lowest_index();
    resp_t o, e; int lat; bit ds;
    prog(4, 16'hF0F0, 99, 5);
    issue_scan(1'b0, 16'hF0F0, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL lowest_idx: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_priority();
    resp_t o, e; int lat; bit ds; bit any_resp;
    wait_ready();
    checkout = 1'b1;
    prog_we = 1'b1; prog_idx = 3'd4; prog_barcode = 16'h7777; prog_cost = 10'd1; prog_qty = 10'd1;
    scan_valid = 1'b1; scan_op = 1'b0; barcode = 16'h7777;
    #1;
    n_cmp++;
    if (scan_ready !== 1'b0) begin n_bad++; $display("FAIL prio_ready: got %b want 0", scan_ready); end
    @(posedge clk); @(negedge clk);
    checkout = 1'b0; prog_we = 1'b0; scan_valid = 1'b0;
    for (int i = 0; i < 5; i++) m_cart[i] = 0;
    m_total = 0;
    m_count = 0;
    n_cmp++;
    if (total_cost !== 14'd0 || item_count !== 8'd0) begin
      n_bad++; $display("FAIL prio_checkout: got tot=%0d cnt=%0d want 0 0", total_cost, item_count);
    end
    any_resp = 1'b0;
    repeat (6) begin
      if (resp_valid !== 1'b0) any_resp = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (any_resp) begin n_bad++; $display("FAIL prio_no_resp: got resp_valid=1 want 0"); end
    issue_scan(1'b0, 16'h7777, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL prio_no_prog: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_prog_range();
    resp_t o, e; int lat; bit ds;
    prog(7, 16'h8888, 1, 1);
    issue_scan(1'b0, 16'h8888, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL prog_range: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_reset_midflight();
    resp_t o, e; int lat; bit ds; bit any_resp;
    issue_scan(1'b0, 16'hF0F0, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL pre_reset_add: got %s want %s", fmt(o), fmt(e)); end
    wait_ready();
    scan_valid = 1'b1; scan_op = 1'b0; barcode = 16'hF0F0;
    @(posedge clk);
    #2;
    scan_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({resp_valid, resp_status, resp_idx, total_cost, item_count, trolley_full, door_open} !== '0) begin
      n_bad++;
      $display("FAIL rst_outputs: got rv=%b st=%0d idx=%0d tot=%0d cnt=%0d full=%b door=%b, want all 0",
               resp_valid, resp_status, resp_idx, total_cost, item_count, trolley_full, door_open);
    end
    model_clear();
    any_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) any_resp = 1'b1;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) any_resp = 1'b1;
    end
    n_cmp++;
    if (any_resp) begin n_bad++; $display("FAIL rst_no_resp: got resp_valid=1 want 0"); end
    issue_scan(1'b0, 16'hF0F0, o, lat, ds);
    e = sb_q.pop_front();
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL rst_table_cleared: got %s want %s", fmt(o), fmt(e)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog_we = 1'b0; prog_idx = '0; prog_barcode = '0; prog_cost = '0; prog_qty = '0;
    scan_valid = 1'b0; scan_op = 1'b0; barcode = '0; checkout = 1'b0;
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_add_ok();
    test_not_found();
    test_no_stock();
    test_full();
    test_remove();
    test_lowest_index();
    test_priority();
    test_prog_range();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trolley_billing.md
TROLLEY_BILLING -- requirements
Module: trolley_billing

Interface
REQ-001 Parameter N_PROD, default 5, number of product table entries.
REQ-002 Parameter BC_W, default 16, barcode width.
REQ-003 Parameter COST_W, default 10, per-item cost width.
REQ-004 Parameter QTY_W, default 10, stock quantity width.
REQ-005 Parameter CAP, default 8, trolley capacity in items (1..255).
REQ-006 Parameter DOOR_CYC, default 4, door-open hold time in clocks (>=1).
REQ-007 Parameter TOT_W, default 14, total-cost width; SHALL be >= COST_W + clog2(CAP+1), else elaboration error.
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 prog_we  in  1  table write strobe.
REQ-011 prog_idx  in  clog2(N_PROD)  entry index to write.
REQ-012 prog_barcode / prog_cost / prog_qty  in  BC_W / COST_W / QTY_W  entry contents.
REQ-013 scan_valid  in  1  scan request.
REQ-014 scan_op  in  1  0 = add item, 1 = remove item.
REQ-015 barcode  in  BC_W  scanned code.
REQ-016 checkout  in  1  clear-trolley pulse.
REQ-017 scan_ready  out  1  scan accepted when scan_valid && scan_ready.
REQ-018 resp_valid  out  1  one-cycle response pulse.
REQ-019 resp_status  out  2  0 OK, 1 NOT_FOUND, 2 NO_STOCK (add) / NOT_IN_TROLLEY (remove), 3 FULL.
REQ-020 resp_idx  out  clog2(N_PROD)  matched entry, 0 if not found.
REQ-021 total_cost  out  TOT_W  running bill.
REQ-022 item_count  out  8  items in trolley.
REQ-023 trolley_full  out  1  item_count == CAP.
REQ-024 door_open  out  1  trolley door open.

Function
REQ-025 FSM states IDLE, LOOKUP, UPDATE, DOOR; scan_ready = (state==IDLE) && !prog_we && !checkout.
REQ-026 In IDLE, priority checkout > prog_we > scan; only one action per cycle; all three ignored outside IDLE.
REQ-027 prog_we writes barcode/cost/qty to entry prog_idx and sets its valid bit; out-of-range prog_idx is ignored.
REQ-028 Accepted scan latches barcode and scan_op, goes IDLE->LOOKUP; LOOKUP compares against all valid entries, lowest index wins, ->UPDATE.
REQ-029 In UPDATE, status selected with priority NOT_FOUND > FULL (add, item_count==CAP) > NO_STOCK (add, qty==0) / NOT_IN_TROLLEY (remove, in_cart[idx]==0).
REQ-030 Add OK: qty[idx]-1, in_cart[idx]+1, item_count+1, total_cost+cost[idx].
REQ-031 Remove OK: qty[idx]+1, in_cart[idx]-1, item_count-1, total_cost-cost[idx]; qty saturates at all-ones (no wrap).
REQ-032 Updates and resp_valid/resp_status/resp_idx become visible together on the clock edge leaving UPDATE; latency from acceptance edge to resp_valid high = 2 clocks.
REQ-033 On OK, UPDATE->DOOR; door_open high for exactly DOOR_CYC clocks, scan_ready low, then ->IDLE; on any error status, UPDATE->IDLE, door_open stays low.
REQ-034 Per-entry in_cart counters are 8 bits; total_cost never wraps given REQ-007.
REQ-035 Checkout clears total_cost, item_count, all in_cart; stock and table unchanged; resp_valid not pulsed.
REQ-036 Table write to an entry mid-operation is impossible (REQ-026); cost used for removal is the current table cost.

Reset
REQ-037 reset low asynchronously forces state IDLE, all outputs 0, all valid bits, qty, in_cart cleared, door counter 0; an in-flight scan is dropped without response.
REQ-038 Operation resumes on the first rising clk after reset deasserts.

Verification
REQ-039 Program entry0 {F0F0, cost 10, qty 16}; add F0F0 -> resp_valid 2 clocks after accept, status 0, idx 0, total 10, count 1, qty 15, door_open 4 clocks.
REQ-040 Scan unknown ABCD (add) -> status 1, idx 0, totals unchanged, door_open never high, scan_ready back after 3 clocks.
REQ-041 Entry qty 1: add twice -> second status 2; CAP=2 with 3 adds of stocked item -> third status 3, trolley_full=1.
REQ-042 Add cost-55 item then remove it -> total 0, qty restored; remove again -> status 2 (NOT_IN_TROLLEY).
REQ-043 Simultaneous checkout, prog_we, scan_valid in IDLE -> only checkout takes effect, scan_ready 0 that cycle.
REQ-044 Assert reset during LOOKUP -> no resp_valid, all outputs 0, table invalid; post-reset scan -> status 1.
